// File: rtl/bldc_commutator.sv
// Six-step trapezoidal BLDC commutator: hall sync/filter, phase drive table, position and stall/fault tracking.
// Optional duty ramp is compiled in when BLDC_DUTY_RAMP_EN is defined.
module bldc_commutator #(
    parameter int DUTY_CYCLE_WIDTH = 10,
    parameter int MAX_DUTY_CYCLE   = 'h3ff,
    parameter int HALL_FILTER      = 4,
    parameter int STALL_TIMEOUT    = 50000,
    parameter int COUNT_WIDTH      = 16,
    parameter int RAMP_STEP        = 1,
    parameter int RAMP_DIV         = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          brake,
    input  logic                          direction,
    input  logic [DUTY_CYCLE_WIDTH-1:0]   duty_cycle,
    input  logic [2:0]                    hall,
    output logic [3*DUTY_CYCLE_WIDTH-1:0] phase_duty,
    output logic [2:0]                    phase_high_z,
    output logic [2:0]                    hall_state,
    output logic [COUNT_WIDTH-1:0]        hall_count,
    output logic                          fault,
    output logic [1:0]                    debug_state
);

    localparam int W  = DUTY_CYCLE_WIDTH;
    localparam int FW = $clog2(HALL_FILTER) + 1;
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [W-1:0] MAX_D = W'(MAX_DUTY_CYCLE);

    if (HALL_FILTER < 2 || STALL_TIMEOUT < 1 || RAMP_STEP < 1 || RAMP_DIV < 1) begin : g_bad_params
        $error("bldc_commutator: HALL_FILTER>=2, STALL_TIMEOUT/RAMP_STEP/RAMP_DIV>=1 required");
    end

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_t;

    state_t          state;
    logic [2:0]      sync1, sync2, cand;
    logic [FW-1:0]   filt_cnt;
    logic            hall_evt;
    logic [SW-1:0]   stall_cnt;
    logic [W-1:0]    target, applied;
    logic [1:0]      plus_ph, minus_ph;

    function automatic logic code_valid(input logic [2:0] c);
        return (c != 3'd0) && (c != 3'd7);
    endfunction

    // Forward rotation order 5,1,3,2,6,4.
    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (c)
            3'd5:    return 3'd1;
            3'd1:    return 3'd3;
            3'd3:    return 3'd2;
            3'd2:    return 3'd6;
            3'd6:    return 3'd4;
            3'd4:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // {plus, minus} phase index (A=0,B=1,C=2); 3 means no phase selected.
    function automatic logic [3:0] drive_pair(input logic [2:0] c);
        case (c)
            3'd5:    return {2'd0, 2'd1};
            3'd1:    return {2'd0, 2'd2};
            3'd3:    return {2'd1, 2'd2};
            3'd2:    return {2'd1, 2'd0};
            3'd6:    return {2'd2, 2'd0};
            3'd4:    return {2'd2, 2'd1};
            default: return {2'd3, 2'd3};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            cand       <= '0;
            filt_cnt   <= '0;
            hall_state <= '0;
            hall_evt   <= 1'b0;
            hall_count <= '0;
        end else begin
            sync1    <= hall;
            sync2    <= sync1;
            hall_evt <= 1'b0;
            if (sync2 != cand) begin
                cand     <= sync2;
                filt_cnt <= FW'(1);
            end else if (filt_cnt != FW'(HALL_FILTER - 1)) begin
                filt_cnt <= filt_cnt + FW'(1);
            end else if (cand != hall_state) begin
                hall_state <= cand;
                hall_evt   <= 1'b1;
                if (code_valid(hall_state) && code_valid(cand)) begin
                    if (cand == next_code(hall_state))
                        hall_count <= hall_count + COUNT_WIDTH'(1);
                    else if (hall_state == next_code(cand))
                        hall_count <= hall_count - COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign target = (duty_cycle > MAX_D) ? MAX_D : duty_cycle;

`ifdef BLDC_DUTY_RAMP_EN
    localparam int DW = $clog2(RAMP_DIV + 1);
    localparam logic [W-1:0] STEP = W'(RAMP_STEP);
    logic [DW-1:0] ramp_div;

    // Final step is trimmed to land exactly on the target.
    always_ff @(posedge clk) begin
        if (reset || state != RUN) begin
            applied  <= '0;
            ramp_div <= '0;
        end else if (ramp_div == DW'(RAMP_DIV - 1)) begin
            ramp_div <= '0;
            if (applied < target)
                applied <= (target - applied > STEP) ? applied + STEP : target;
            else if (applied > target)
                applied <= (applied - target > STEP) ? applied - STEP : target;
        end else begin
            ramp_div <= ramp_div + DW'(1);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) applied <= '0;
        else       applied <= target;
    end
`endif

    always_comb begin
        {plus_ph, minus_ph} = drive_pair(hall_state);
        if (direction) {plus_ph, minus_ph} = {minus_ph, plus_ph};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            stall_cnt    <= '0;
            phase_duty   <= '0;
            phase_high_z <= 3'b111;
        end else begin
            // Counter only runs in RUN, so leaving and re-entering RUN starts it from zero.
            if (state != RUN || hall_evt)
                stall_cnt <= '0;
            else if (applied != '0 && stall_cnt != SW'(STALL_TIMEOUT))
                stall_cnt <= stall_cnt + SW'(1);

            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:  if (brake) state <= BRAKE;
                           else if (code_valid(hall_state)) state <= RUN;
                    RUN:   if (!code_valid(hall_state) || stall_cnt == SW'(STALL_TIMEOUT)) state <= FAULT;
                           else if (brake) state <= BRAKE;
                    BRAKE: if (!brake && code_valid(hall_state)) state <= RUN;
                    default: state <= FAULT;
                endcase
            end

            for (int i = 0; i < 3; i++) begin
                phase_duty[i*W +: W] <= '0;
                phase_high_z[i]      <= 1'b1;
                if (state == RUN) begin
                    if (2'(i) == plus_ph) begin
                        phase_duty[i*W +: W] <= applied;
                        phase_high_z[i]      <= 1'b0;
                    end else if (2'(i) == minus_ph) begin
                        phase_high_z[i] <= 1'b0;
                    end
                end else if (state == BRAKE) begin
                    phase_high_z[i] <= 1'b0;
                end
            end
        end
    end

    assign fault       = (state == FAULT);
    assign debug_state = state;

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: vector table plus hand sequences for hall latency, glitch rejection and stall.
// Expected output words are queued when stimulus is driven and popped when the settled outputs are sampled.
module tb_bldc_commutator;

    localparam int W  = 10;
    localparam int CW = 16;
    localparam int OW = 1 + 3 + 3 + 3*W + CW;
    localparam int STALL = 300;
    localparam logic [W-1:0] MAXD = 10'h3f0;

    logic            clk = 1'b0;
    logic            reset, en, brake, direction;
    logic [W-1:0]    duty_cycle;
    logic [2:0]      hall;
    logic [3*W-1:0]  phase_duty;
    logic [2:0]      phase_high_z, hall_state;
    logic [CW-1:0]   hall_count;
    logic            fault;
    logic [1:0]      debug_state;

    bldc_commutator #(
        .DUTY_CYCLE_WIDTH(W), .MAX_DUTY_CYCLE(int'(MAXD)), .HALL_FILTER(4),
        .STALL_TIMEOUT(STALL), .COUNT_WIDTH(CW), .RAMP_STEP(1), .RAMP_DIV(64)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .brake(brake), .direction(direction),
        .duty_cycle(duty_cycle), .hall(hall), .phase_duty(phase_duty),
        .phase_high_z(phase_high_z), .hall_state(hall_state), .hall_count(hall_count),
        .fault(fault), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, brake, dir;
        logic [W-1:0]  duty;
        logic [2:0]    hall;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t          vecs[24];
    logic [OW-1:0] exp_q[$];
    int            n_vec  = 0;
    int            n_fail = 0;

    function automatic logic [OW-1:0] pk(input logic f, input logic [2:0] hs, input logic [2:0] hz,
                                         input logic [W-1:0] dc, input logic [W-1:0] db,
                                         input logic [W-1:0] da, input logic [CW-1:0] cnt);
        return {f, hs, hz, dc, db, da, cnt};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic b, input logic d, input logic [W-1:0] dc,
                         input logic [2:0] h);
        en = e; brake = b; direction = d; duty_cycle = dc; hall = h;
    endtask

    task automatic check(input string name);
        logic [OW-1:0] e, a;
        a = {fault, hall_state, phase_high_z, phase_duty, hall_count};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got f=%0b hs=%0d hz=%b duty=%h cnt=%0d, want f=%0b hs=%0d hz=%b duty=%h cnt=%0d",
                         name, a[OW-1], a[OW-2 -: 3], a[OW-5 -: 3], a[CW +: 3*W], a[CW-1:0],
                         e[OW-1], e[OW-2 -: 3], e[OW-5 -: 3], e[CW +: 3*W], e[CW-1:0]);
            end
        end
    endtask

    initial begin
        logic [W-1:0] d, dexp;

        //        en    br    dir   duty    hall  expected {f, hs, hz, C, B, A, cnt}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd5, pk(0, 5, 3'b100, 0, 0, 200, 0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd1, pk(0, 1, 3'b010, 0, 0, 200, 1)};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd3, pk(0, 3, 3'b001, 0, 200, 0, 2)};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 10'd200, 3'd3, pk(0, 3, 3'b001, 200, 0, 0, 2)};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 10'd200, 3'd2, pk(0, 2, 3'b100, 0, 0, 200, 3)};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd6, pk(0, 6, 3'b010, 200, 0, 0, 4)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd2, pk(0, 2, 3'b100, 0, 200, 0, 3)};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd5, pk(0, 5, 3'b100, 0, 0, 200, 3)};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 10'd200, 3'd4, pk(0, 4, 3'b001, 200, 0, 0, 2)};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 10'd1023, 3'd4, pk(0, 4, 3'b001, 10'h3f0, 0, 0, 2)};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 10'h3f0, 3'd5, pk(0, 5, 3'b100, 0, 0, 10'h3f0, 3)};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 10'h3ef, 3'd5, pk(0, 5, 3'b100, 0, 0, 10'h3ef, 3)};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 10'h3ef, 3'd5, pk(0, 5, 3'b000, 0, 0, 0, 3)};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 10'h3ef, 3'd1, pk(0, 1, 3'b000, 0, 0, 0, 4)};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 10'h3ef, 3'd7, pk(0, 7, 3'b000, 0, 0, 0, 4)};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 10'h3ef, 3'd7, pk(0, 7, 3'b000, 0, 0, 0, 4)};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 10'h3ef, 3'd1, pk(0, 1, 3'b010, 0, 0, 10'h3ef, 4)};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 10'h3ef, 3'd7, pk(1, 7, 3'b111, 0, 0, 0, 4)};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 10'h3ef, 3'd7, pk(1, 7, 3'b111, 0, 0, 0, 4)};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 10'h3ef, 3'd5, pk(1, 5, 3'b111, 0, 0, 0, 4)};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 10'h3ef, 3'd5, pk(0, 5, 3'b111, 0, 0, 0, 4)};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 10'h3ef, 3'd1, pk(0, 1, 3'b111, 0, 0, 0, 5)};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 10'd50,  3'd1, pk(0, 1, 3'b000, 0, 0, 0, 5)};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 10'd50,  3'd1, pk(0, 1, 3'b010, 0, 0, 50, 5)};

        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 10'd200, 3'd5);
        tick(1);
        reset = 1'b0;
        exp_q.push_back(pk(0, 0, 3'b111, 0, 0, 0, 0));
        tick(1);
        check("reset");

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].en, vecs[i].brake, vecs[i].dir, vecs[i].duty, vecs[i].hall);
            exp_q.push_back(vecs[i].exp);
            tick(12);
            check($sformatf("vec%0d", i));
        end

        // Random duty requests in RUN at hall 1 (A high side), clamp at MAXD.
        for (int i = 0; i < 4; i++) begin
            d = W'($urandom_range(0, 1023));
            dexp = (d > MAXD) ? MAXD : d;
            duty_cycle = d;
            exp_q.push_back(pk(0, 1, 3'b010, 0, 0, dexp, 5));
            tick(3);
            check($sformatf("rand_duty%0d", i));
        end
        duty_cycle = 10'd50;
        tick(3);

        // Exact latency: hall_state 2+4 cycles after the pin, outputs one cycle later.
        hall = 3'd3;
        exp_q.push_back(pk(0, 1, 3'b010, 0, 0, 50, 5));
        tick(5);
        check("lat_before");
        exp_q.push_back(pk(0, 3, 3'b010, 0, 0, 50, 6));
        tick(1);
        check("lat_hall_state");
        exp_q.push_back(pk(0, 3, 3'b001, 0, 50, 0, 6));
        tick(1);
        check("lat_outputs");

        // Three-cycle glitch must be rejected.
        hall = 3'd2;
        tick(3);
        hall = 3'd3;
        exp_q.push_back(pk(0, 3, 3'b001, 0, 50, 0, 6));
        tick(12);
        check("glitch");

        // Stall: hall frozen with nonzero duty.
        hall = 3'd2;
        exp_q.push_back(pk(0, 2, 3'b100, 0, 50, 0, 7));
        tick(256);
        check("stall_pre");
        for (int i = 0; i < 100 && !fault; i++) tick(1);
        n_vec++;
        if (!fault) begin
            n_fail++;
            $display("FAIL stall_fault: fault=%0b after timeout budget, want 1", fault);
        end
        tick(1);
        exp_q.push_back(pk(1, 2, 3'b111, 0, 0, 0, 7));
        check("stall_fault_outputs");

        en = 1'b0;
        exp_q.push_back(pk(0, 2, 3'b111, 0, 0, 0, 7));
        tick(3);
        check("stall_clear");

        // Zero duty never stalls.
        drive(1'b1, 1'b0, 1'b0, 10'd0, 3'd2);
        exp_q.push_back(pk(0, 2, 3'b100, 0, 0, 0, 7));
        tick(STALL + 100);
        check("zero_duty_no_stall");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
